// File: rtl/apb_cmd_master_if.sv
// Command/response stream plus APB bus bundle for apb_cmd_master.
// master = APB initiator side, slave = sequencer and peripheral side.
interface apb_cmd_master_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata,
    output rsp_err, busy,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata,
    input  rsp_err, busy,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_cmd_master.sv
// APB3 initiator: FIFO-buffered valid/ready commands -> APB transfers.
// Define APB_PREADY_EN to honour PREADY with a wait-state timeout.
module apb_cmd_master #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input logic              PCLK,
  input logic              PRESETN,
  apb_cmd_master_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t      state;
  cmd_t        mem [FIFO_DEPTH];
  cmd_t        head;
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        done;

  // extra pointer bit separates full from empty
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign push  = bus.cmd_valid && !full;
  assign head  = mem[rd_ptr[PW-1:0]];

  assign bus.cmd_ready = !full;
  assign bus.busy      = !empty || (state != IDLE);

`ifdef APB_PREADY_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wcnt;
  logic          tmo;
  assign done = bus.PREADY;
  assign tmo  = !bus.PREADY && (wcnt == CW'(TIMEOUT - 1));
`else
  logic [31:0] unused_cfg;
  assign done        = 1'b1;
  assign unused_cfg  = 32'(TIMEOUT) ^ {31'd0, bus.PREADY};
  assign bus.rsp_err = 1'b0;
`endif

  // pop only from IDLE or at a completing ACCESS
  assign pop = !empty &&
               ((state == IDLE) || ((state == ACCESS) && done));

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[PW-1:0]] <= {bus.cmd_write, bus.cmd_addr,
                                bus.cmd_wdata};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state         <= IDLE;
      bus.PSEL      <= 1'b0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PADDR     <= '0;
      bus.PWDATA    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_write <= 1'b0;
      bus.rsp_rdata <= '0;
`ifdef APB_PREADY_EN
      bus.rsp_err   <= 1'b0;
      wcnt          <= '0;
`endif
    end else begin
      bus.rsp_valid <= 1'b0;
      if (pop) begin
        bus.PADDR  <= head.addr;
        bus.PWRITE <= head.write;
        bus.PWDATA <= head.write ? head.wdata : '0;
      end
      unique case (state)
        IDLE: begin
          if (pop) begin
            state    <= SETUP;
            bus.PSEL <= 1'b1;
          end
        end
        SETUP: begin
          state       <= ACCESS;
          bus.PENABLE <= 1'b1;
`ifdef APB_PREADY_EN
          wcnt        <= '0;
`endif
        end
        ACCESS: begin
          if (done) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_write <= bus.PWRITE;
            bus.rsp_rdata <= bus.PWRITE ? '0 : bus.PRDATA;
`ifdef APB_PREADY_EN
            bus.rsp_err   <= 1'b0;
`endif
            bus.PENABLE   <= 1'b0;
            bus.PSEL      <= pop;
            state         <= pop ? SETUP : IDLE;
          end
`ifdef APB_PREADY_EN
          else if (tmo) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_write <= bus.PWRITE;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b1;
            bus.PENABLE   <= 1'b0;
            bus.PSEL      <= 1'b0;
            state         <= IDLE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed + randomized bench for apb_cmd_master.
// Reference: in-order queues of expected APB transfers and responses.
module tb_apb_cmd_master;
  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic pready = 1'b1;
  int   checks = 0;
  int   errors = 0;

`ifdef APB_PREADY_EN
  localparam bit PR_EN = 1'b1;
`else
  localparam bit PR_EN = 1'b0;
`endif

  typedef struct {
    logic       w;
    logic [3:0] a;
    logic [7:0] d;
  } apb_t;

  typedef struct {
    logic       w;
    logic [7:0] rd;
    logic       err;
  } rsp_t;

  logic [7:0] slave_mem  [16];
  logic [7:0] model_regs [16];
  apb_t       exp_apb [$];
  rsp_t       exp_rsp [$];

  int rsp_cnt   = 0;
  int pen_cnt   = 0;
  int psel_cnt  = 0;
  int gap_cnt   = 0;
  bit burst     = 0;
  bit seen_psel = 0;
  bit saw_full  = 0;

  always #5 clk = ~clk;

  apb_cmd_master_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  apb_cmd_master dut (
    .PCLK    (clk),
    .PRESETN (rst_n),
    .bus     (bus)
  );

  assign bus.PREADY = pready;
  assign bus.PRDATA = slave_mem[bus.PADDR];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // what the spec says one accepted command must produce
  task automatic model_cmd(input logic w, input logic [3:0] a,
                           input logic [7:0] d, input bit tmo);
    rsp_t r;
    if (!tmo) exp_apb.push_back('{w, a, w ? d : 8'h00});
    r.w   = w;
    r.err = tmo;
    r.rd  = (w || tmo) ? 8'h00 : model_regs[a];
    exp_rsp.push_back(r);
    if (w && !tmo) model_regs[a] = d;
  endtask

  task automatic send(input logic w, input logic [3:0] a,
                      input logic [7:0] d, input bit tmo);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_ready_timeout", bus.cmd_ready, 1);
    model_cmd(w, a, d, tmo);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus.busy, 0);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (bus.PENABLE) pen_cnt++;
    if (!bus.cmd_ready) saw_full = 1'b1;
    if (burst) begin
      if (bus.PSEL) begin
        seen_psel = 1'b1;
        psel_cnt++;
      end else if (seen_psel && bus.busy) begin
        gap_cnt++;
      end
    end
    if (bus.PSEL && bus.PENABLE && (!PR_EN || bus.PREADY)) begin
      if (exp_apb.size() == 0) begin
        chk("apb_unexpected", bus.PSEL, 0);
      end else begin
        apb_t e;
        e = exp_apb.pop_front();
        chk("apb_addr", bus.PADDR, e.a);
        chk("apb_write", bus.PWRITE, e.w);
        chk("apb_wdata", bus.PWDATA, e.d);
        if (bus.PWRITE) slave_mem[bus.PADDR] = bus.PWDATA;
      end
    end
    if (bus.rsp_valid) begin
      rsp_cnt++;
      if (exp_rsp.size() == 0) begin
        chk("rsp_unexpected", bus.rsp_valid, 0);
      end else begin
        rsp_t r;
        r = exp_rsp.pop_front();
        chk("rsp_write", bus.rsp_write, r.w);
        chk("rsp_rdata", bus.rsp_rdata, r.rd);
        chk("rsp_err", bus.rsp_err, r.err);
      end
    end
  end

  initial begin
    int c0;
    for (int i = 0; i < 16; i++) begin
      slave_mem[i]  = 8'(i * 17 + 3);
      model_regs[i] = slave_mem[i];
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    repeat (3) @(negedge clk);

    chk("rst_psel", bus.PSEL, 0);
    chk("rst_penable", bus.PENABLE, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_paddr", bus.PADDR, 0);
    chk("rst_pwdata", bus.PWDATA, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // write 0xA5 to 0x1, latency edge by edge
    send(1'b1, 4'h1, 8'hA5, 1'b0);
    chk("t1_k_psel", bus.PSEL, 0);
    chk("t1_k_busy", bus.busy, 1);
    @(negedge clk);
    chk("t1_k1_psel", bus.PSEL, 1);
    chk("t1_k1_penable", bus.PENABLE, 0);
    chk("t1_k1_pwrite", bus.PWRITE, 1);
    chk("t1_k1_paddr", bus.PADDR, 4'h1);
    chk("t1_k1_pwdata", bus.PWDATA, 8'hA5);
    @(negedge clk);
    chk("t1_k2_penable", bus.PENABLE, 1);
    chk("t1_k2_paddr", bus.PADDR, 4'h1);
    chk("t1_k2_rsp_valid", bus.rsp_valid, 0);
    @(negedge clk);
    chk("t1_k3_rsp_valid", bus.rsp_valid, 1);
    chk("t1_k3_rsp_write", bus.rsp_write, 1);
    chk("t1_k3_rsp_rdata", bus.rsp_rdata, 8'h00);
    chk("t1_k3_psel", bus.PSEL, 0);
    wait_idle("t1_idle");
    chk("t1_paddr_hold", bus.PADDR, 4'h1);

    // read 0x2 returning 0x3C; wdata must be masked
    slave_mem[2]  = 8'h3C;
    model_regs[2] = 8'h3C;
    send(1'b0, 4'h2, 8'hFF, 1'b0);
    @(negedge clk);
    chk("t2_pwrite", bus.PWRITE, 0);
    chk("t2_pwdata", bus.PWDATA, 8'h00);
    chk("t2_paddr", bus.PADDR, 4'h2);
    @(negedge clk);
    chk("t2_penable", bus.PENABLE, 1);
    @(negedge clk);
    chk("t2_rsp_valid", bus.rsp_valid, 1);
    chk("t2_rsp_rdata", bus.rsp_rdata, 8'h3C);
    chk("t2_rsp_err", bus.rsp_err, 0);
    wait_idle("t2_idle");

    // 8 back-to-back commands with cmd_valid held
    saw_full  = 1'b0;
    gap_cnt   = 0;
    psel_cnt  = 0;
    seen_psel = 1'b0;
    burst     = 1'b1;
    c0        = rsp_cnt;
    for (int i = 0; i < 8; i++)
      send(1'($urandom), 4'($urandom), 8'($urandom), 1'b0);
    wait_idle("t3_idle");
    burst = 1'b0;
    chk("t3_saw_full", saw_full, 1);
    chk("t3_idle_gaps", gap_cnt, 0);
    chk("t3_psel_cycles", psel_cnt, 16);
    chk("t3_rsp_count", rsp_cnt - c0, 8);

    // random traffic with random gaps
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
`ifndef APB_PREADY_EN
      pready = 1'($urandom);
`endif
      send(1'($urandom), 4'($urandom), 8'($urandom), 1'b0);
    end
    wait_idle("rand_idle");
    pready = 1'b1;
    chk("rand_apb_q", exp_apb.size(), 0);
    chk("rand_rsp_q", exp_rsp.size(), 0);

    // reset in the ACCESS of a read
    send(1'b0, 4'h7, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("t4_in_access", bus.PENABLE, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_psel", bus.PSEL, 0);
    chk("t4_penable", bus.PENABLE, 0);
    chk("t4_rsp_valid", bus.rsp_valid, 0);
    exp_rsp.delete();
    exp_apb.delete();
    c0 = rsp_cnt;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t4_no_rsp", rsp_cnt - c0, 0);
    chk("t4_cmd_ready", bus.cmd_ready, 1);
    chk("t4_busy", bus.busy, 0);
    send(1'b1, 4'h3, 8'h5A, 1'b0);
    wait_idle("t4_after");
    chk("t4_after_rsp", rsp_cnt - c0, 1);

`ifdef APB_PREADY_EN
    // three wait states on a read of 0x5A
    slave_mem[4]  = 8'h5A;
    model_regs[4] = 8'h5A;
    pready  = 1'b0;
    pen_cnt = 0;
    send(1'b0, 4'h4, 8'h00, 1'b0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 pready = 1'b1;
    wait_idle("t5_idle");
    chk("t5_penable_cycles", pen_cnt, 4);

    // timeout, then the queued write proceeds
    pready  = 1'b0;
    pen_cnt = 0;
    c0      = rsp_cnt;
    send(1'b0, 4'h6, 8'h00, 1'b1);
    send(1'b1, 4'h9, 8'hC3, 1'b0);
    begin
      int n = 0;
      while (!bus.rsp_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t6_rsp_seen", bus.rsp_valid, 1);
    chk("t6_penable_cycles", pen_cnt, 16);
    chk("t6_psel_dropped", bus.PSEL, 0);
    chk("t6_err", bus.rsp_err, 1);
    #1 pready = 1'b1;
    wait_idle("t6_idle");
    chk("t6_rsp_count", rsp_cnt - c0, 2);
`endif

    chk("end_apb_q", exp_apb.size(), 0);
    chk("end_rsp_q", exp_rsp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
